io_bus_arb: RTL

IO_BUS_ARB -- requirements
Module: io_bus_arb

---
 rtl/io_bus_arb_if.sv | 30 +++
 rtl/io_bus_arb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/io_bus_arb_if.sv
// Bus bundle between two requesters, the arbiter and the DMA IO chain.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface io_bus_arb_if;
    logic        m0_req,   m1_req;
    logic        m0_we,    m1_we;
    logic [15:2] m0_adr,   m1_adr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack,   m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        dma_io_we;
    logic [15:2] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [15:2] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_wdata, m1_wdata,
        input  dma_io_rdata_in,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
        output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_adr, m1_adr, m0_wdata, m1_wdata,
        output dma_io_rdata_in,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
        input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_radr_en
    );
endinterface

// File: rtl/io_bus_arb.sv
// Two-requester round-robin arbiter onto the DMA IO bus; one transaction in flight,
// every output registered, reads wait RD_LAT cycles for the IO chain to answer.
module io_bus_arb #(
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    io_bus_arb_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, RACK} state_e;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        last_m1_q, last_m1_d;
    logic        gnt_m1_q, gnt_m1_d;
    logic        we_q, we_d;
    logic [15:2] wadr_q, wadr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        radr_en_q, radr_en_d;
    logic [15:2] radr_q, radr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        pick_m1;
    logic        sel_we;
    logic [15:2] sel_adr;
    logic [31:0] sel_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_m1_d = last_m1_q;
        gnt_m1_d  = gnt_m1_q;
        we_d      = 1'b0;
        wadr_d    = '0;
        wdata_d   = '0;
        radr_en_d = 1'b0;
        radr_d    = '0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        // On a tie the requester that did not win last time takes the bus.
        pick_m1   = bus.m1_req && (!bus.m0_req || !last_m1_q);
        sel_we    = pick_m1 ? bus.m1_we    : bus.m0_we;
        sel_adr   = pick_m1 ? bus.m1_adr   : bus.m0_adr;
        sel_wdata = pick_m1 ? bus.m1_wdata : bus.m0_wdata;

        case (state_q)
            IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    gnt_m1_d  = pick_m1;
                    last_m1_d = pick_m1;
                    // The bus output flops are the grant-time capture of adr/wdata.
                    if (sel_we) begin
                        state_d = WR;
                        we_d    = 1'b1;
                        wadr_d  = sel_adr;
                        wdata_d = sel_wdata;
                        ack0_d  = !pick_m1;
                        ack1_d  = pick_m1;
                    end else begin
                        state_d   = RD;
                        radr_en_d = 1'b1;
                        radr_d    = sel_adr;
                    end
                end
            end
            WR: state_d = IDLE;
            RD: begin
                state_d = RWAIT;
                cnt_d   = '0;
            end
            RWAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RACK;
                    cnt_d   = '0;
                    ack0_d  = !gnt_m1_q;
                    ack1_d  = gnt_m1_q;
                    if (gnt_m1_q) rdata1_d = bus.dma_io_rdata_in;
                    else          rdata0_d = bus.dma_io_rdata_in;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_m1_q <= 1'b1;
            gnt_m1_q  <= 1'b0;
            we_q      <= 1'b0;
            wadr_q    <= '0;
            wdata_q   <= '0;
            radr_en_q <= 1'b0;
            radr_q    <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_m1_q <= last_m1_d;
            gnt_m1_q  <= gnt_m1_d;
            we_q      <= we_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            radr_en_q <= radr_en_d;
            radr_q    <= radr_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign bus.dma_io_we      = we_q;
    assign bus.dma_io_wadr    = wadr_q;
    assign bus.dma_io_wdata   = wdata_q;
    assign bus.dma_io_radr_en = radr_en_q;
    assign bus.dma_io_radr    = radr_q;
    assign bus.m0_ack         = ack0_q;
    assign bus.m1_ack         = ack1_q;
    assign bus.m0_rdata       = rdata0_q;
    assign bus.m1_rdata       = rdata1_q;

endmodule
